fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO, successor of the fixed 8-bit x 16 transaction-layer FIFO.

---
 rtl/fifo_sync_param_pkg.sv | 21 ++
 rtl/fifo_sync_param_if.sv | 35 +++
 rtl/fifo_sync_param_ram_dp.sv | 25 ++
 rtl/fifo_sync_param.sv | 103 ++++++++++
 tb/tb_fifo_sync_param.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared defaults, read-mode constants and operation decode for the parametrised sync FIFO.
package fifo_sync_param_pkg;

    localparam int unsigned DATA_W_DFLT = 8;
    localparam int unsigned ADDR_W_DFLT = 4;
    localparam int unsigned FWFT_STD    = 0;
    localparam int unsigned FWFT_ON     = 1;

    // Accepted operation on an edge; encoding is {read, write}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WR    = 2'b01,
        OP_RD    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e op_of(input logic wr_ok, input logic rd_ok);
        return fifo_op_e'({rd_ok, wr_ok});
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the sync FIFO: data path, thresholds, status and error flags.
interface fifo_sync_param_if
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned ADDR_W = ADDR_W_DFLT
);
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [ADDR_W:0]   af_thresh;
    logic [ADDR_W:0]   ae_thresh;
    logic              clr_err;
    logic [ADDR_W:0]   count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              almost_empty;
    logic              fifo_overflow;
    logic              fifo_underflow;

    modport master (
        output wr, data_in, rd, af_thresh, ae_thresh, clr_err,
        input  data_out, data_valid, count, fifo_full, fifo_empty,
               almost_full, almost_empty, fifo_overflow, fifo_underflow
    );

    modport slave (
        input  wr, data_in, rd, af_thresh, ae_thresh, clr_err,
        output data_out, data_valid, count, fifo_full, fifo_empty,
               almost_full, almost_empty, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/fifo_sync_param_ram_dp.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_sync_param_ram_dp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, sticky errors and
// selectable standard / first-word-fall-through read mode.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned FWFT   = FWFT_STD
) (
    input logic              clk,
    input logic              rst,
    fifo_sync_param_if.slave bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              full;
    logic              empty;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_data;
    fifo_op_e          op;

    // Status is derived from the registered count so it moves the cycle after an accept
    assign full  = (count == PTR_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = bus.wr && !full;
    assign rd_ok = bus.rd && !empty;
    assign op    = op_of(wr_ok, rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr <= wptr + PTR_W'(wr_ok);
            rptr <= rptr + PTR_W'(rd_ok);
            case (op)
                OP_WR:   count <= count + PTR_W'(1);
                OP_RD:   count <= count - PTR_W'(1);
                default: count <= count;
            endcase
            // A new error in the same cycle as clr_err wins
            overflow  <= (overflow  && !bus.clr_err) || (bus.wr && full);
            underflow <= (underflow && !bus.clr_err) || (bus.rd && empty);
        end
    end

    fifo_sync_param_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .waddr   (wptr[ADDR_W-1:0]),
        .wdata   (bus.data_in),
        .raddr   (rptr[ADDR_W-1:0]),
        .rdata_c (rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; rd only advances the read pointer
            assign bus.data_out   = rd_data;
            assign bus.data_valid = !empty;
        end else begin : g_std
            logic [DATA_W-1:0] dout;
            logic              dvalid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout   <= '0;
                    dvalid <= 1'b0;
                end else begin
                    dvalid <= rd_ok;
                    if (rd_ok) begin
                        dout <= rd_data;
                    end
                end
            end

            assign bus.data_out   = dout;
            assign bus.data_valid = dvalid;
        end
    endgenerate

    assign bus.count          = count;
    assign bus.fifo_full      = full;
    assign bus.fifo_empty     = empty;
    assign bus.almost_full    = (count >= bus.af_thresh);
    assign bus.almost_empty   = (count <= bus.ae_thresh);
    assign bus.fifo_overflow  = overflow;
    assign bus.fifo_underflow = underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard and an FWFT instance with identical traffic and checks both
// against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) i0 ();
    fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) i1 ();

    fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (i0.slave)
    );

    fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (i1.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_unf;
    logic [7:0] m_dout;
    bit         m_dv;
    int         af_t;
    int         ae_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_thresh(input int af, input int ae);
        af_t = af;
        ae_t = ae;
        i0.af_thresh = 5'(af);
        i1.af_thresh = 5'(af);
        i0.ae_thresh = 5'(ae);
        i1.ae_thresh = 5'(ae);
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count0", 32'(i0.count), 32'(n));
        chk("count1", 32'(i1.count), 32'(n));
        chk("full0", 32'(i0.fifo_full), 32'(n == DEPTH));
        chk("full1", 32'(i1.fifo_full), 32'(n == DEPTH));
        chk("empty0", 32'(i0.fifo_empty), 32'(n == 0));
        chk("empty1", 32'(i1.fifo_empty), 32'(n == 0));
        chk("afull0", 32'(i0.almost_full), 32'(n >= af_t));
        chk("afull1", 32'(i1.almost_full), 32'(n >= af_t));
        chk("aempty0", 32'(i0.almost_empty), 32'(n <= ae_t));
        chk("aempty1", 32'(i1.almost_empty), 32'(n <= ae_t));
        chk("ovf0", 32'(i0.fifo_overflow), 32'(m_ovf));
        chk("ovf1", 32'(i1.fifo_overflow), 32'(m_ovf));
        chk("unf0", 32'(i0.fifo_underflow), 32'(m_unf));
        chk("unf1", 32'(i1.fifo_underflow), 32'(m_unf));
        chk("dvalid0", 32'(i0.data_valid), 32'(m_dv));
        chk("dout0", 32'(i0.data_out), 32'(m_dout));
        chk("dvalid1", 32'(i1.data_valid), 32'(n != 0));
        if (n != 0) begin
            chk("dout1", 32'(i1.data_out), 32'(q[0]));
        end
    endtask

    // One clock: drive inputs, advance the model with pre-edge occupancy, then compare
    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rdq, input bit clr);
        bit was_full;
        bit was_empty;
        rst        = r;
        i0.wr      = w;    i1.wr      = w;
        i0.data_in = d;    i1.data_in = d;
        i0.rd      = rdq;  i1.rd      = rdq;
        i0.clr_err = clr;  i1.clr_err = clr;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r) begin
            q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = 8'h00;
            m_dv   = 1'b0;
        end else begin
            m_ovf = (m_ovf && !clr) || (w && was_full);
            m_unf = (m_unf && !clr) || (rdq && was_empty);
            m_dv  = 1'b0;
            if (rdq && !was_empty) begin
                m_dout = q.pop_front();
                m_dv   = 1'b1;
            end
            if (w && !was_full) begin
                q.push_back(d);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        set_thresh(12, 3);
        i0.wr = 1'b0; i1.wr = 1'b0;
        i0.rd = 1'b0; i1.rd = 1'b0;
        i0.data_in = '0; i1.data_in = '0;
        i0.clr_err = 1'b0; i1.clr_err = 1'b0;

        // Reset, some traffic, then a two-cycle reset mid-traffic
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h30 + i), (i > 2), 0);
        step(1, 1, 8'h77, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("rst_count", 32'(i0.count), 32'd0);
        chk("rst_dvalid", 32'(i0.data_valid), 32'd0);

        // Fill, then one write too many
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i), 0, 0);
            if (i == 11) chk("af_at_12", 32'(i0.almost_full), 32'd1);
        end
        chk("full_at_16", 32'(i0.fifo_full), 32'd1);
        step(0, 1, 8'hEE, 0, 0);
        chk("ovf_17th", 32'(i1.fifo_overflow), 32'd1);

        // Drain in order, one read too many, then clear errors
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1, 0);
        chk("last_word", 32'(i0.data_out), 32'h0F);
        step(0, 0, 8'h00, 1, 0);
        chk("unf_extra", 32'(i0.fifo_underflow), 32'd1);
        step(0, 0, 8'h00, 0, 1);
        chk("clr_ovf", 32'(i0.fifo_overflow), 32'd0);

        // Steady-state wrap with occupancy 5
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1, 0);
        chk("wrap_count", 32'(i1.count), 32'd5);

        // Full + wr + rd, then empty + wr + rd
        for (int i = 0; i < 11; i++) step(0, 1, 8'($urandom), 0, 0);
        step(0, 1, 8'h5A, 1, 0);
        chk("fullwr_cnt", 32'(i0.count), 32'd15);
        chk("fullwr_ovf", 32'(i0.fifo_overflow), 32'd1);
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h3C, 1, 0);
        chk("emptywr_cnt", 32'(i0.count), 32'd1);
        chk("emptywr_unf", 32'(i0.fifo_underflow), 32'd1);

        // Fall-through visibility of a single word
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'hA5, 0, 0);
        chk("fwft_data", 32'(i1.data_out), 32'hA5);
        chk("fwft_valid", 32'(i1.data_valid), 32'd1);

        // Randomised traffic with changing thresholds and rare resets
        for (int i = 0; i < 3000; i++) begin
            int th[5];
            th = '{0, 3, 12, 16, 20};
            if ($urandom_range(0, 99) == 0) begin
                set_thresh(th[$urandom_range(0, 4)], th[$urandom_range(0, 4)]);
            end
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 40)),
                 8'($urandom),
                 ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 40 : 60)),
                 ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
